am2901_useq: RTL and testbench

Microprogram sequencer that produces the next control-store address for the Am2901 datapath slice and its controller decode. Each cycle it selects the next address from the microprogram counter, the pipeline branch field, the mapping field, or a subroutine/loop stack, using a 3-bit next-address opcode and a test condition. The selected address drives the control-store ROM. The ROM's pipeline register then supplies the `i[8:0]`, `a`, and `b` fields to the datapath controller.

---
 rtl/am2901_useq.sv | 154 +++++++++++++++
 tb/tb_am2901_useq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/am2901_useq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | am2901_useq : next-microaddress sequencer (uPC, loop counter R, stack)     |
// | Option macro: AM2901_USEQ_STACK_ERR_EN adds sticky stack_err output.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module am2901_useq #(
  parameter int AW          = 12,
  parameter int STACK_DEPTH = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    i,
  input  logic          cc_n,
  input  logic          ccen_n,
  input  logic [AW-1:0] d,
  input  logic          rld_n,
  output logic [AW-1:0] y,
  output logic          pl_n,
  output logic          map_n,
  output logic          full_n,
  output logic          empty
`ifdef AM2901_USEQ_STACK_ERR_EN
  ,
  output logic          stack_err
`endif
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);
  localparam logic [SPW-1:0] c_sp_full = SPW'(STACK_DEPTH);
  localparam logic [IW-1:0]  c_top_idx = IW'(STACK_DEPTH - 1);

  typedef enum logic [2:0] {
    OP_JZ   = 3'd0,
    OP_CJS  = 3'd1,
    OP_JMAP = 3'd2,
    OP_CJP  = 3'd3,
    OP_PUSH = 3'd4,
    OP_RFCT = 3'd5,
    OP_CRTN = 3'd6,
    OP_CONT = 3'd7
  } op_e;

  logic [AW-1:0]  r_upc;
  logic [AW-1:0]  r_cnt;
  logic [SPW-1:0] r_sp;
  logic [AW-1:0]  r_stack [STACK_DEPTH];

  logic           w_pass;
  logic           w_full;
  logic           w_empty;
  logic [IW-1:0]  w_tos_idx;
  logic [IW-1:0]  w_wr_idx;
  logic [AW-1:0]  w_tos;
  logic           w_push;
  logic           w_pop;
  logic           w_clr_sp;
  logic           w_dec;
  logic           w_ld;

  assign w_pass    = ccen_n | ~cc_n;
  assign w_full    = (r_sp == c_sp_full);
  assign w_empty   = (r_sp == '0);
  assign w_tos_idx = IW'(r_sp - 1'b1);
  // A push into a full stack overwrites the top entry rather than spilling.
  assign w_wr_idx  = w_full ? c_top_idx : IW'(r_sp);
  assign w_tos     = w_empty ? '0 : r_stack[w_tos_idx];
  assign w_ld      = ~rld_n | ((i == OP_PUSH) & w_pass);
  assign full_n    = ~w_full;
  assign empty     = w_empty;

  always_comb begin
    y        = r_upc;
    pl_n     = 1'b0;
    map_n    = 1'b1;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_clr_sp = 1'b0;
    w_dec    = 1'b0;
    case (i)
      OP_JZ: begin
        y        = '0;
        w_clr_sp = 1'b1;
      end
      OP_CJS: begin
        if (w_pass) begin
          y      = d;
          w_push = 1'b1;
        end
      end
      OP_JMAP: begin
        y     = d;
        pl_n  = 1'b1;
        map_n = 1'b0;
      end
      OP_CJP: begin
        if (w_pass) y = d;
      end
      OP_PUSH: w_push = 1'b1;
      OP_RFCT: begin
        if (r_cnt != '0) begin
          y     = w_tos;
          w_dec = 1'b1;
        end else begin
          w_pop = 1'b1;
        end
      end
      OP_CRTN: begin
        if (w_pass) begin
          y     = w_tos;
          w_pop = 1'b1;
        end
      end
      default: ;
    endcase
    if (reset) begin
      y     = '0;
      pl_n  = 1'b0;
      map_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_upc <= '0;
      r_cnt <= '0;
      r_sp  <= '0;
    end else begin
      r_upc <= y + 1'b1;
      if (w_ld)       r_cnt <= d;
      else if (w_dec) r_cnt <= r_cnt - 1'b1;
      if (w_clr_sp)                r_sp <= '0;
      else if (w_push && !w_full)  r_sp <= r_sp + 1'b1;
      else if (w_pop && !w_empty)  r_sp <= r_sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_stack[w_wr_idx] <= r_upc;
  end

`ifdef AM2901_USEQ_STACK_ERR_EN
  logic r_stack_err;
  assign stack_err = r_stack_err;

  always_ff @(posedge clk) begin
    if (reset || (i == OP_JZ))                        r_stack_err <= 1'b0;
    else if ((w_push && w_full) || (w_pop && w_empty)) r_stack_err <= 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_am2901_useq.sv
`default_nettype none
// Bench for am2901_useq: directed vector table, hand sequences, random vs queue model.
module tb_am2901_useq;
  localparam int AW = 12;
  localparam int SD = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    i = 3'd7;
  logic          cc_n = 1'b1, ccen_n = 1'b1, rld_n = 1'b1;
  logic [AW-1:0] d = '0;
  logic [AW-1:0] y;
  logic          pl_n, map_n, full_n, empty;
`ifdef AM2901_USEQ_STACK_ERR_EN
  logic          stack_err;
`endif

  am2901_useq #(.AW(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .i(i), .cc_n(cc_n), .ccen_n(ccen_n),
    .d(d), .rld_n(rld_n), .y(y), .pl_n(pl_n), .map_n(map_n),
    .full_n(full_n), .empty(empty)
`ifdef AM2901_USEQ_STACK_ERR_EN
    , .stack_err(stack_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: stack as a bounded queue, plain integer arithmetic.
  int m_upc = 0, m_r = 0;
  int m_stk[$];
  bit m_err = 0;

  function automatic int m_tos();
    return (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
  endfunction

  function automatic int m_y();
    bit p = ccen_n | ~cc_n;
    if (reset) return 0;
    case (int'(i))
      0: return 0;
      1: return p ? int'(d) : m_upc;
      2: return int'(d);
      3: return p ? int'(d) : m_upc;
      5: return (m_r != 0) ? m_tos() : m_upc;
      6: return p ? m_tos() : m_upc;
      default: return m_upc;
    endcase
  endfunction

  task automatic m_edge();
    bit p = ccen_n | ~cc_n;
    int yy = m_y();
    bit do_push = 0, do_pop = 0, ev = 0;
    if (reset) begin
      m_upc = 0; m_r = 0; m_stk.delete(); m_err = 0;
      return;
    end
    case (int'(i))
      0: m_stk.delete();
      1: do_push = p;
      4: do_push = 1;
      5: do_pop = (m_r == 0);
      6: do_pop = p;
      default: ;
    endcase
    if (do_push) begin
      if (m_stk.size() < SD) m_stk.push_back(m_upc);
      else begin m_stk[SD-1] = m_upc; ev = 1; end
    end
    if (do_pop) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else ev = 1;
    end
    if (!rld_n || (i == 3'd4 && p)) m_r = int'(d);
    else if (i == 3'd5 && m_r != 0) m_r = m_r - 1;
    if (i == 3'd0) m_err = 0;
    else if (ev) m_err = 1;
    m_upc = (yy + 1) % (1 << AW);
  endtask

  task automatic drive(input int op, input int cc, input int ccen, input int dd,
                       input int rld, input int rst);
    @(negedge clk);
    i = 3'(op); cc_n = 1'(cc); ccen_n = 1'(ccen); d = AW'(dd);
    rld_n = 1'(rld); reset = 1'(rst);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
  endtask

  task automatic chk_model(input string tag);
    bit jm = !reset && (i == 3'd2);
    chk({tag, ".y"},      32'(y),      32'(m_y()));
    chk({tag, ".pl_n"},   32'(pl_n),   32'(jm));
    chk({tag, ".map_n"},  32'(map_n),  32'(!jm));
    chk({tag, ".full_n"}, 32'(full_n), 32'(m_stk.size() != SD));
    chk({tag, ".empty"},  32'(empty),  32'(m_stk.size() == 0));
`ifdef AM2901_USEQ_STACK_ERR_EN
    chk({tag, ".stack_err"}, 32'(stack_err), 32'(m_err));
`endif
  endtask

  typedef struct {
    int op, cc, ccen, dd, rld;
    int ey, epl, emap, eemp, efull;
  } vec_t;

  function automatic vec_t mk(int op, int cc, int ccen, int dd, int rld,
                              int ey, int epl, int emap, int eemp, int efull);
    vec_t v;
    v.op = op; v.cc = cc; v.ccen = ccen; v.dd = dd; v.rld = rld;
    v.ey = ey; v.epl = epl; v.emap = emap; v.eemp = eemp; v.efull = efull;
    return v;
  endfunction

  vec_t tbl[24];

  initial begin
    tbl[0]  = mk(7,1,1,'h000,1, 'h000,0,1,1,1);
    tbl[1]  = mk(7,1,1,'h000,1, 'h001,0,1,1,1);
    tbl[2]  = mk(7,1,1,'h000,1, 'h002,0,1,1,1);
    tbl[3]  = mk(7,1,1,'h000,1, 'h003,0,1,1,1);
    tbl[4]  = mk(3,1,0,'h120,1, 'h004,0,1,1,1);
    tbl[5]  = mk(3,1,1,'h120,1, 'h120,0,1,1,1);
    tbl[6]  = mk(7,1,1,'h000,1, 'h121,0,1,1,1);
    tbl[7]  = mk(3,0,0,'h00F,1, 'h00F,0,1,1,1);
    tbl[8]  = mk(1,0,0,'h200,1, 'h200,0,1,1,1);
    tbl[9]  = mk(7,1,1,'h000,1, 'h201,0,1,0,1);
    tbl[10] = mk(6,1,0,'h000,1, 'h202,0,1,0,1);
    tbl[11] = mk(6,0,0,'h000,1, 'h010,0,1,0,1);
    tbl[12] = mk(7,1,1,'h000,1, 'h011,0,1,1,1);
    tbl[13] = mk(2,1,1,'h3A5,1, 'h3A5,1,0,1,1);
    tbl[14] = mk(7,1,1,'h000,1, 'h3A6,0,1,1,1);
    tbl[15] = mk(3,0,0,'h02F,1, 'h02F,0,1,1,1);
    tbl[16] = mk(4,0,0,'h003,1, 'h030,0,1,1,1);
    tbl[17] = mk(5,1,1,'h000,1, 'h030,0,1,0,1);
    tbl[18] = mk(5,1,1,'h000,1, 'h030,0,1,0,1);
    tbl[19] = mk(5,1,1,'h000,1, 'h030,0,1,0,1);
    tbl[20] = mk(5,1,1,'h000,1, 'h031,0,1,0,1);
    tbl[21] = mk(7,1,1,'h000,1, 'h032,0,1,1,1);
    tbl[22] = mk(4,0,0,'h005,1, 'h033,0,1,1,1);
    tbl[23] = mk(5,1,1,'h009,0, 'h033,0,1,0,1);

    // Reset held two cycles with CONT on the opcode lines.
    @(posedge clk); m_edge();
    drive(7,1,1,0,1,1);
    chk("rst.y", 32'(y), 0); chk("rst.pl_n", 32'(pl_n), 0); chk("rst.map_n", 32'(map_n), 1);
    tick();
    drive(7,1,1,0,1,1);
    chk("rst2.y", 32'(y), 0); chk("rst2.empty", 32'(empty), 1); chk("rst2.full_n", 32'(full_n), 1);
    tick();

    foreach (tbl[k]) begin
      drive(tbl[k].op, tbl[k].cc, tbl[k].ccen, tbl[k].dd, tbl[k].rld, 0);
      chk($sformatf("vec%0d.y", k),      32'(y),      32'(tbl[k].ey));
      chk($sformatf("vec%0d.pl_n", k),   32'(pl_n),   32'(tbl[k].epl));
      chk($sformatf("vec%0d.map_n", k),  32'(map_n),  32'(tbl[k].emap));
      chk($sformatf("vec%0d.empty", k),  32'(empty),  32'(tbl[k].eemp));
      chk($sformatf("vec%0d.full_n", k), 32'(full_n), 32'(tbl[k].efull));
      tick();
    end

    // R was reloaded to 9 (not decremented to 4): nine more loop-backs, then exit.
    for (int k = 0; k < 9; k++) begin
      drive(5,1,1,0,1,0);
      chk($sformatf("rld_loop%0d.y", k), 32'(y), 'h033);
      tick();
    end
    drive(5,1,1,0,1,0);
    chk("rld_exit.y", 32'(y), 'h034);
    tick();
    drive(7,1,1,0,1,0);
    chk("rld_after.y", 32'(y), 'h035); chk("rld_after.empty", 32'(empty), 1);
    tick();

    // Stack overflow / underflow.
    drive(0,1,1,0,1,0);
    chk("jz.y", 32'(y), 0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      drive(4,1,0,0,1,0);
      chk($sformatf("push%0d.y", k), 32'(y), 32'(k));
      chk($sformatf("push%0d.full_n", k), 32'(full_n), 32'(k != 6));
      tick();
    end
    drive(7,1,1,0,1,0);
    chk("full.full_n", 32'(full_n), 0); chk("full.empty", 32'(empty), 0);
`ifdef AM2901_USEQ_STACK_ERR_EN
    chk("ovf.stack_err", 32'(stack_err), 1);
`endif
    tick();
    begin
      int exp_pop[6] = '{6, 4, 3, 2, 1, 0};
      for (int k = 0; k < 6; k++) begin
        drive(6,0,0,0,1,0);
        chk($sformatf("crtn%0d.y", k), 32'(y), 32'(exp_pop[k]));
        tick();
      end
    end
    drive(0,1,1,0,1,0);
    chk("unf.empty", 32'(empty), 1);
`ifdef AM2901_USEQ_STACK_ERR_EN
    chk("unf.stack_err", 32'(stack_err), 1);
`endif
    tick();
    drive(7,1,1,0,1,0);
`ifdef AM2901_USEQ_STACK_ERR_EN
    chk("jzclr.stack_err", 32'(stack_err), 0);
`endif
    chk("jzclr.y", 32'(y), 1);
    tick();

    // Reset overrides a taken jump combinationally and discards stack state.
    drive(4,0,0,'h007,1,0); tick();
    drive(3,0,0,'h555,1,1);
    chk("rstjmp.y", 32'(y), 0); chk("rstjmp.pl_n", 32'(pl_n), 0); chk("rstjmp.map_n", 32'(map_n), 1);
    tick();
    drive(5,1,1,0,1,0);
    chk("rstpost.y", 32'(y), 0); chk("rstpost.empty", 32'(empty), 1);
    tick();

    for (int k = 0; k < 600; k++) begin
      int dd = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, (1 << AW) - 1));
      drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            dd, ($urandom_range(0, 7) == 0) ? 0 : 1, ($urandom_range(0, 60) == 0) ? 1 : 0);
      chk_model($sformatf("rnd%0d", k));
      tick();
    end

    // Upper-address wrap of the microprogram counter.
    drive(3,1,1,(1 << AW) - 1,1,0); tick();
    drive(7,1,1,0,1,0);
    chk("wrap.y", 32'(y), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
